typing_checker: RTL and testbench



---
 rtl/typing_checker.sv | 186 ++++++++++++++++++
 tb/tb_typing_checker.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_checker.sv
// typing_checker: judges PS/2 keystrokes against the expected character of the
// current word, pulses get_next_character on every correct key and
// enable_next_level to request the next word; tracks level, progress and score.
//
// Ports:
//   clk, resetn (synchronous, active-low)
//   start                     one-cycle pulse, begins the game from idle
//   key_valid, key_code       PS/2 byte strobe and byte from the receiver
//   expected_code, num_char   current expected scan code and word length
//   get_next_character        one-cycle pulse after each correct key
//   enable_next_level         one-cycle pulse requesting the next word
//   level, char_index         current word index, correct chars in this word
//   correct_count, error_count  saturating keystroke totals
//   word_done, game_over      word-complete pulse, terminal game-over level
//
// Optional: define ERROR_LIMIT_EN to end the game once error_count reaches
// MAX_ERRORS. Without it errors are only counted.

module typing_checker #(
  parameter int NUM_LEVELS       = 30,
  parameter int LOAD_WAIT_CYCLES = 4,
  parameter int MAX_ERRORS       = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic [7:0] expected_code,
  input  logic [7:0] num_char,
  output logic       get_next_character,
  output logic       enable_next_level,
  output logic [4:0] level,
  output logic [7:0] char_index,
  output logic [7:0] correct_count,
  output logic [7:0] error_count,
  output logic       word_done,
  output logic       game_over
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] WAIT_LAST  = 8'(LOAD_WAIT_CYCLES - 1);
  localparam logic [4:0] LAST_LEVEL = 5'(NUM_LEVELS - 1);
  localparam logic [7:0] ERR_LIMIT  = 8'(MAX_ERRORS);
`ifdef ERROR_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_TYPE, S_ADV, S_DONE, S_OVER
  } state_t;

  state_t     state, state_d;
  logic [7:0] wait_cnt;

  // Byte filter state: pending break/extended prefixes and the key currently
  // held down (used to swallow typematic repeats).
  logic       break_pend, break_pend_d;
  logic       ext_pend, ext_pend_d;
  logic       held_vld, held_vld_d;
  logic [7:0] held_code, held_code_d;
  logic       judgeable;

  logic       inc_correct, inc_error, inc_level, clr_index;
  logic       key_match;
  logic [7:0] error_sat;

  assign key_match = (key_code == expected_code);
  assign error_sat = (error_count == 8'hFF) ? 8'hFF : error_count + 8'd1;

  // Filter runs in every state so the held key stays accurate even while the
  // FSM is not judging (e.g. a key pressed during the word-load wait).
  always_comb begin
    break_pend_d = break_pend;
    ext_pend_d   = ext_pend;
    held_vld_d   = held_vld;
    held_code_d  = held_code;
    judgeable    = 1'b0;
    if (key_valid) begin
      if (key_code == CODE_BREAK) begin
        break_pend_d = 1'b1;
      end else if (key_code == CODE_EXT) begin
        ext_pend_d = 1'b1;
      end else if (break_pend) begin
        // Break byte (plain or extended): release, never judged.
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
        if (held_vld && (held_code == key_code)) begin
          held_vld_d = 1'b0;
        end
      end else if (ext_pend) begin
        ext_pend_d = 1'b0;
      end else if (!(held_vld && (held_code == key_code))) begin
        held_vld_d  = 1'b1;
        held_code_d = key_code;
        judgeable   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    inc_correct = 1'b0;
    inc_error   = 1'b0;
    inc_level   = 1'b0;
    clr_index   = 1'b0;
    case (state)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (wait_cnt == WAIT_LAST) state_d = S_TYPE;
      S_TYPE: begin
        if (num_char == 8'd0) begin
          state_d = S_DONE;
        end else if (judgeable) begin
          if (key_match) begin
            inc_correct = 1'b1;
            state_d     = S_ADV;
          end else begin
            inc_error = 1'b1;
            if (LIMIT_ON && (error_sat == ERR_LIMIT)) state_d = S_OVER;
          end
        end
      end
      // One cycle here gives the shift stage time to present the new
      // expected_code before the next judgement.
      S_ADV:  state_d = (char_index == num_char) ? S_DONE : S_TYPE;
      S_DONE: begin
        clr_index = 1'b1;
        if (level == LAST_LEVEL) begin
          state_d = S_OVER;
        end else begin
          inc_level = 1'b1;
          state_d   = S_REQ;
        end
      end
      // Terminal: the upstream word address only returns to zero on resetn.
      S_OVER: state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt      <= 8'd0;
      level         <= 5'd0;
      char_index    <= 8'd0;
      correct_count <= 8'd0;
      error_count   <= 8'd0;
      break_pend    <= 1'b0;
      ext_pend      <= 1'b0;
      held_vld      <= 1'b0;
      held_code     <= 8'd0;
    end else begin
      break_pend <= break_pend_d;
      ext_pend   <= ext_pend_d;
      held_vld   <= held_vld_d;
      held_code  <= held_code_d;
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (inc_correct) begin
        correct_count <= (correct_count == 8'hFF) ? 8'hFF : correct_count + 8'd1;
        char_index    <= char_index + 8'd1;
      end else if (clr_index) begin
        char_index <= 8'd0;
      end
      if (inc_error) error_count <= error_sat;
      if (inc_level) level <= level + 5'd1;
    end
  end

  assign get_next_character = (state == S_ADV);
  assign enable_next_level  = (state == S_REQ);
  assign word_done          = (state == S_DONE);
  assign game_over          = (state == S_OVER);

endmodule

// File: tb/tb_typing_checker.sv
module tb_typing_checker;

  localparam int NUM_LEVELS = 30;
  localparam int LOAD_WAIT  = 4;
  localparam int MAX_ERR    = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'd0;
  logic [7:0] expected_code = 8'd0;
  logic [7:0] num_char = 8'd0;
  logic       get_next_character, enable_next_level, word_done, game_over;
  logic [4:0] level;
  logic [7:0] char_index, correct_count, error_count;

  typing_checker #(
    .NUM_LEVELS(NUM_LEVELS), .LOAD_WAIT_CYCLES(LOAD_WAIT), .MAX_ERRORS(MAX_ERR)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key_valid(key_valid),
    .key_code(key_code), .expected_code(expected_code), .num_char(num_char),
    .get_next_character(get_next_character), .enable_next_level(enable_next_level),
    .level(level), .char_index(char_index), .correct_count(correct_count),
    .error_count(error_count), .word_done(word_done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [32:0] act, input logic [32:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (gnc,enl,lvl,idx,cc,ec,wd,go)", name, act, req);
    end
  endtask

  function automatic logic [32:0] dut_vec();
    return {get_next_character, enable_next_level, level, char_index,
            correct_count, error_count, word_done, game_over};
  endfunction

  // ---------------- reference model ----------------
  // Game described as a timeline: a request pulse, a quiet load period,
  // typing, a one-cycle advance after each hit and a one-cycle word end.
  bit m_enl, m_gnc, m_wd, m_over, m_play, m_brk, m_ext;
  int m_wait, m_lvl, m_idx, m_cc, m_ec, m_held;

  function automatic logic [32:0] model_vec();
    return {m_gnc, m_enl, 5'(m_lvl), 8'(m_idx), 8'(m_cc), 8'(m_ec), m_wd, m_over};
  endfunction

  task automatic model_step(input bit rn, input bit st, input bit kv,
                            input logic [7:0] kc, input logic [7:0] ex, input logic [7:0] nc);
    bit judge, p_enl, p_gnc, p_wd;
    if (!rn) begin
      m_enl = 0; m_gnc = 0; m_wd = 0; m_over = 0; m_play = 0; m_brk = 0; m_ext = 0;
      m_wait = 0; m_lvl = 0; m_idx = 0; m_cc = 0; m_ec = 0; m_held = -1;
      return;
    end
    judge = 0;
    if (kv) begin
      if (kc == 8'hF0) m_brk = 1;
      else if (kc == 8'hE0) m_ext = 1;
      else if (m_brk) begin
        m_brk = 0; m_ext = 0;
        if (m_held == int'(kc)) m_held = -1;
      end else if (m_ext) m_ext = 0;
      else if (m_held != int'(kc)) begin
        m_held = int'(kc); judge = 1;
      end
    end
    p_enl = m_enl; p_gnc = m_gnc; p_wd = m_wd;
    m_enl = 0; m_gnc = 0; m_wd = 0;
    if (m_over) begin
    end else if (!m_play) begin
      if (st) begin m_play = 1; m_enl = 1; end
    end else if (p_enl) begin
      m_wait = LOAD_WAIT;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (p_gnc) begin
      if (m_idx == int'(nc)) m_wd = 1;
    end else if (p_wd) begin
      m_idx = 0;
      if (m_lvl == NUM_LEVELS - 1) m_over = 1;
      else begin m_lvl++; m_enl = 1; end
    end else begin
      if (nc == 8'd0) m_wd = 1;
      else if (judge) begin
        if (kc == ex) begin
          m_cc = (m_cc < 255) ? m_cc + 1 : 255;
          m_idx = (m_idx + 1) % 256;
          m_gnc = 1;
        end else begin
          m_ec = (m_ec < 255) ? m_ec + 1 : 255;
`ifdef ERROR_LIMIT_EN
          if (m_ec == MAX_ERR) m_over = 1;
`endif
        end
      end
    end
  endtask

  // ---------------- drive helpers ----------------
  task automatic tick();
    model_step(resetn, start, key_valid, key_code, expected_code, num_char);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 0; start = 0; key_valid = 0;
    tick(); tick();
    resetn = 1;
  endtask

  task automatic send(input logic [7:0] b);
    key_code = b; key_valid = 1;
    tick();
    key_valid = 0;
  endtask

  task automatic begin_game();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] key, exp, nc;
    int gnc, enl, wd, idx, cc, ec, lvl;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic [7:0] k, input logic [7:0] e, input logic [7:0] n,
                              input int g, input int en, input int w,
                              input int i, input int c, input int er, input int l);
    row_t r;
    r.key = k; r.exp = e; r.nc = n;
    r.gnc = g; r.enl = en; r.wd = w; r.idx = i; r.cc = c; r.ec = er; r.lvl = l;
    return r;
  endfunction

  task automatic apply_row(input row_t r, input int n);
    int g = 0, e = 0, w = 0;
    expected_code = r.exp; num_char = r.nc;
    send(r.key);
    g += int'(get_next_character); e += int'(enable_next_level); w += int'(word_done);
    for (int i = 0; i < 8; i++) begin
      tick();
      g += int'(get_next_character); e += int'(enable_next_level); w += int'(word_done);
    end
    check($sformatf("row%0d_gnc", n), g, r.gnc);
    check($sformatf("row%0d_enl", n), e, r.enl);
    check($sformatf("row%0d_wd", n), w, r.wd);
    check($sformatf("row%0d_idx", n), int'(char_index), r.idx);
    check($sformatf("row%0d_cc", n), int'(correct_count), r.cc);
    check($sformatf("row%0d_ec", n), int'(error_count), r.ec);
    check($sformatf("row%0d_lvl", n), int'(level), r.lvl);
  endtask

  // ---------------- random environment ----------------
  logic [7:0] words[NUM_LEVELS][6];
  int         lens[NUM_LEVELS];
  int         w_idx, w_ptr, load_cnt;
  logic [7:0] pool[14] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                           8'h43, 8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B};

  task automatic env_drive();
    int wi;
    if (w_idx < 0) begin
      expected_code = 8'h00; num_char = 8'd0;
    end else begin
      wi = w_idx % NUM_LEVELS;
      num_char = 8'(lens[wi]);
      expected_code = (w_ptr < lens[wi]) ? words[wi][w_ptr] : 8'h00;
    end
  endtask

  initial begin
    int enl_cnt, enl_c1, seen, go_low, g_cnt;
    logic [7:0] last_sent;

    // --- reset state and start/load-wait timing ---
    do_reset();
    check_vec("reset_outputs", dut_vec(), 33'd0);
    expected_code = 8'h24; num_char = 8'd3;
    enl_cnt = 0; enl_c1 = 0;
    for (int c = 0; c < 7; c++) begin
      start = (c == 0);
      key_valid = (c == 3 || c == 5 || c == 6);
      key_code = (c == 5) ? 8'h1C : 8'h24;
      tick();
      start = 0; key_valid = 0;
      enl_cnt += int'(enable_next_level);
      if (c == 0) enl_c1 = int'(enable_next_level);
      if (c == 5) begin
        check("wait_cc", int'(correct_count), 0);
        check("wait_ec", int'(error_count), 0);
      end
      if (c == 6) begin
        check("first_gnc", int'(get_next_character), 1);
        check("first_cc", int'(correct_count), 1);
        check("first_idx", int'(char_index), 1);
      end
    end
    check("start_enl_cycle1", enl_c1, 1);
    check("start_enl_once", enl_cnt, 1);

    // --- table-driven keystroke rows ---
    rows.push_back(mk(8'h24, 8'h24, 3, 1,0,0, 1,1,0,0));
    rows.push_back(mk(8'hF0, 8'h21, 3, 0,0,0, 1,1,0,0));
    rows.push_back(mk(8'h24, 8'h21, 3, 0,0,0, 1,1,0,0));
    rows.push_back(mk(8'h21, 8'h21, 3, 1,0,0, 2,2,0,0));
    rows.push_back(mk(8'hF0, 8'h2B, 3, 0,0,0, 2,2,0,0));
    rows.push_back(mk(8'h21, 8'h2B, 3, 0,0,0, 2,2,0,0));
    rows.push_back(mk(8'h2B, 8'h2B, 3, 1,1,1, 0,3,0,1));
    rows.push_back(mk(8'hF0, 8'h24, 2, 0,0,0, 0,3,0,1));
    rows.push_back(mk(8'h2B, 8'h24, 2, 0,0,0, 0,3,0,1));
    rows.push_back(mk(8'h1C, 8'h24, 2, 0,0,0, 0,3,1,1));
    rows.push_back(mk(8'hF0, 8'h24, 2, 0,0,0, 0,3,1,1));
    rows.push_back(mk(8'h1C, 8'h24, 2, 0,0,0, 0,3,1,1));
    rows.push_back(mk(8'h24, 8'h24, 2, 1,0,0, 1,4,1,1));
    rows.push_back(mk(8'h24, 8'h24, 2, 0,0,0, 1,4,1,1));
    rows.push_back(mk(8'h24, 8'h24, 2, 0,0,0, 1,4,1,1));
    rows.push_back(mk(8'hF0, 8'h24, 2, 0,0,0, 1,4,1,1));
    rows.push_back(mk(8'h24, 8'h24, 2, 0,0,0, 1,4,1,1));
    rows.push_back(mk(8'h24, 8'h24, 2, 1,1,1, 0,5,1,2));
    rows.push_back(mk(8'hE0, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'h75, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'hE0, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'hF0, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'h75, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'hF0, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'h24, 8'h75, 1, 0,0,0, 0,5,1,2));
    rows.push_back(mk(8'h75, 8'h75, 1, 1,1,1, 0,6,1,3));

    do_reset();
    expected_code = 8'h24; num_char = 8'd3;
    begin_game();
    foreach (rows[i]) apply_row(rows[i], i);

    // --- empty word completes immediately ---
    num_char = 8'd0;
    tick();
    check("empty_word_done", int'(word_done), 1);
    tick();
    check("empty_word_enl", int'(enable_next_level), 1);
    check("empty_word_lvl", int'(level), 4);

    // --- run to the last level and finish the game ---
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (level == 5'd29) seen = 1;
    end
    check("reach_last_level", seen, 1);
    num_char = 8'd1; expected_code = 8'h5A;
    for (int i = 0; i < 6; i++) tick();
    send(8'h5A);
    check("last_gnc", int'(get_next_character), 1);
    tick();
    check("last_word_done", int'(word_done), 1);
    check("last_go_not_yet", int'(game_over), 0);
    tick();
    check("game_over_set", int'(game_over), 1);
    check("game_over_lvl", int'(level), 29);
    check("game_over_cc", int'(correct_count), 7);
    enl_cnt = 0; go_low = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      tick();
      start = 0;
      enl_cnt += int'(enable_next_level);
      go_low += int'(!game_over);
    end
    check("over_no_enl", enl_cnt, 0);
    check("over_sticky", go_low, 0);

    // --- error limit / saturation ---
    do_reset();
    expected_code = 8'h24; num_char = 8'd3;
    begin_game();
    g_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      send((i % 2) ? 8'h1B : 8'h1C);
      g_cnt += int'(get_next_character) + int'(enable_next_level);
      tick();
    end
    check("err9_count", int'(error_count), 9);
    check("err9_not_over", int'(game_over), 0);
    send(8'h1B);
    g_cnt += int'(get_next_character) + int'(enable_next_level);
    check("err10_count", int'(error_count), 10);
`ifdef ERROR_LIMIT_EN
    check("err10_game_over", int'(game_over), 1);
    tick();
    g_cnt += int'(get_next_character) + int'(enable_next_level);
    check("err10_no_pulses", g_cnt, 0);
`else
    check("err10_no_game_over", int'(game_over), 0);
    tick();
    for (int i = 0; i < 250; i++) begin
      send((i % 2) ? 8'h1B : 8'h1C);
      g_cnt += int'(get_next_character) + int'(enable_next_level);
    end
    check("err_saturate", int'(error_count), 255);
    check("err_no_pulses", g_cnt, 0);
`endif

    // --- randomized run against the reference model ---
    for (int i = 0; i < NUM_LEVELS; i++) begin
      lens[i] = $urandom_range(0, 5);
      for (int j = 0; j < 6; j++) words[i][j] = pool[$urandom_range(0, 13)];
    end
    w_idx = -1; w_ptr = 0; load_cnt = 0; last_sent = 8'h24;
    do_reset();
    for (int cyc = 0; cyc < 8000 && bad < 10; cyc++) begin
      int r;
      resetn = ($urandom_range(0, 1999) != 0);
      start = ($urandom_range(0, 29) == 0);
      key_valid = ($urandom_range(0, 2) == 0);
      env_drive();
      r = $urandom_range(0, 9);
      if (r <= 3) key_code = expected_code;
      else if (r <= 5) key_code = 8'hF0;
      else if (r == 6) key_code = 8'hE0;
      else if (r == 7) key_code = last_sent;
      else key_code = pool[$urandom_range(0, 13)];
      if (key_valid) last_sent = key_code;
      tick();
      check_vec($sformatf("rand_cycle%0d", cyc), dut_vec(), model_vec());
      if (!resetn) begin
        w_idx = -1; w_ptr = 0; load_cnt = 0;
      end else begin
        if (get_next_character) w_ptr++;
        if (enable_next_level) load_cnt = 3;
        else if (load_cnt > 0) begin
          load_cnt--;
          if (load_cnt == 0) begin w_idx++; w_ptr = 0; end
        end
      end
    end
    resetn = 1; start = 0; key_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
